// File: rtl/pwm_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module : pwm_capture_pkg
//  Brief  : Shared constants for the PWM capture block: default clock rate,
//           counter width, loss-of-signal timeout and FSM state encoding.
//  Rev    : 1.0  initial release
// ============================================================================
package pwm_capture_pkg;

    // System clock in MHz; used only to derive human-readable constants.
    localparam int c_SYS_FREQ    = 125;
    // Counter width: 2^27 clocks is just over 1 s at 125 MHz.
    localparam int c_CNT_W       = 27;
    // Clocks without the expected edge before loss of signal (40 ms @ 125 MHz).
    localparam int c_TIMEOUT_CYC = 5_000_000;
    // Timeout expressed in microseconds, for register maps and documentation.
    localparam int c_TIMEOUT_US  = c_TIMEOUT_CYC / c_SYS_FREQ;

    // FSM state encoding
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_HIGH = 2'd1;
    localparam logic [1:0] c_LOW  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/pwm_capture_sync_edge_detect.sv
`default_nettype none
// ============================================================================
//  Module : sync_edge_detect
//  Brief  : Two-flop synchroniser for an asynchronous input followed by one
//           edge-detect register. Reusable for buttons, echo pins, PWM inputs.
//  Ports  : clk      in  system clock
//           reset_n  in  asynchronous active-low reset
//           async_in in  asynchronous input pin
//           level    out synchronised level
//           rise     out one-clock pulse on a synchronised rising edge
//           fall     out one-clock pulse on a synchronised falling edge
//  Rev    : 1.0  initial release
// ============================================================================
module sync_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= async_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // All three outputs decode registers only, so they are glitch-free.
    assign level = r_s2;
    assign rise  = r_s2 & ~r_s3;
    assign fall  = ~r_s2 & r_s3;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module : pwm_capture
//  Brief  : Measures an external PWM / servo pulse train in system clocks.
//           Reports period and high time once per completed cycle with a
//           one-clock valid strobe, and flags loss of signal on timeout.
//  Ports  : clk       in  system clock (rising edge)
//           reset_n   in  asynchronous active-low reset
//           pwm_in    in  asynchronous PWM input from pin
//           period    out clocks between the last two rising edges
//           high_time out clocks from last rising edge to following falling edge
//           valid     out one-clock strobe: period/high_time just updated
//           timeout   out level: signal lost (stuck high or low)
//  Rev    : 1.0  initial release
// ============================================================================
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = c_CNT_W,
    // Must be below 2^CNT_W so the saturating counter can reach it.
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

    logic             w_level;
    logic             w_rise;
    logic             w_fall;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_expired;

    sync_edge_detect u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (pwm_in),
        .level    (w_level),
        .rise     (w_rise),
        .fall     (w_fall)
    );

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + c_ONE;
    // >= rather than == so that an edge winning the tie on the exact compare
    // cycle (leaving the count one past the limit) still times out next clock.
    assign w_expired = (r_cnt >= c_TIMEOUT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_hcnt    <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // A fall here belongs to a cycle we never saw start.
                    if (w_rise) begin
                        r_cnt   <= c_ONE;
                        r_state <= c_HIGH;
                    end
                end
                c_HIGH: begin
                    // The edge is checked first so it beats a same-cycle timeout.
                    if (w_fall) begin
                        r_hcnt  <= r_cnt;
                        r_cnt   <= w_cnt_inc;
                        r_state <= c_LOW;
                    end else if (w_expired && w_level) begin
                        timeout <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                c_LOW: begin
                    if (w_rise) begin
                        period    <= r_cnt;
                        high_time <= r_hcnt;
                        valid     <= 1'b1;
                        timeout   <= 1'b0;
                        r_cnt     <= c_ONE;
                        r_state   <= c_HIGH;
                    end else if (w_expired && !w_level) begin
                        timeout <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module : tb_pwm_capture
//  Brief  : Self-checking bench for pwm_capture. An edge-timestamp model
//           predicts the outputs every cycle; literal checks pin the model.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_pwm_capture;

    localparam int CNT_W = 27;
    localparam int TMO   = 5000;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             timeout;

    int n_chk  = 0;
    int n_fail = 0;

    pwm_capture #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pwm_in    (pwm_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: timestamps of sampled input edges take effect two clocks
    // later; measurements are differences between those timestamps.
    // ------------------------------------------------------------------
    typedef struct { int t; bit is_rise; } edge_t;
    edge_t q[$];
    int    cyc = 0;
    bit    prev;
    int    phase;        // 0 = waiting for rise, 1 = high, 2 = low
    int    t_rise, t_fall;
    longint exp_period, exp_high;
    bit    exp_valid, exp_tmo;

    always @(posedge clk) begin
        cyc++;
        if (!reset_n) begin
            q.delete();
            prev = 0; phase = 0; t_rise = 0; t_fall = 0;
            exp_period = 0; exp_high = 0; exp_valid = 0; exp_tmo = 0;
        end else begin
            if (pwm_in && !prev) q.push_back('{cyc + 2, 1'b1});
            if (!pwm_in && prev) q.push_back('{cyc + 2, 1'b0});
            prev = pwm_in;
            exp_valid = 0;
            if (q.size() > 0 && q[0].t == cyc) begin
                if (q[0].is_rise) begin
                    if (phase == 2) begin
                        exp_period = cyc - t_rise;
                        exp_high   = t_fall - t_rise;
                        exp_valid  = 1;
                        exp_tmo    = 0;
                    end
                    t_rise = cyc;
                    phase  = 1;
                end else if (phase == 1) begin
                    t_fall = cyc;
                    phase  = 2;
                end
                void'(q.pop_front());
            end else if (phase != 0 && cyc - t_rise >= TMO) begin
                exp_tmo = 1;
                phase   = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("model_valid",     valid,     exp_valid);
            chk("model_timeout",   timeout,   exp_tmo);
            chk("model_period",    period,    exp_period);
            chk("model_high_time", high_time, exp_high);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic pwm_cycles(input int per, input int hi, input int n);
        for (int c = 0; c < n; c++)
            for (int i = 0; i < per; i++) begin
                @(negedge clk);
                pwm_in = (i < hi);
            end
    endtask

    task automatic hold(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            pwm_in = v;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        pwm_in  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_period",  period,    0);
        chk("reset_high",    high_time, 0);
        chk("reset_valid",   valid,     0);
        chk("reset_timeout", timeout,   0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1-clk pulses every 7 clocks
        pwm_cycles(7, 1, 6);
        chk("p7_period", period,    7);
        chk("p7_high",   high_time, 1);

        // 1000/100 loopback, then duty step to 500
        pwm_cycles(1000, 100, 4);
        chk("lb_period", period,    1000);
        chk("lb_high",   high_time, 100);
        chk("lb_tmo",    timeout,   0);
        pwm_cycles(1000, 500, 2);
        chk("duty_period", period,    1000);
        chk("duty_high",   high_time, 500);

        // stuck low -> timeout, values hold; resume clears it
        hold(1'b0, 6000);
        chk("low_tmo",    timeout,   1);
        chk("low_period", period,    1000);
        chk("low_high",   high_time, 500);
        pwm_cycles(1000, 100, 3);
        chk("resume_tmo",  timeout,   0);
        chk("resume_high", high_time, 100);

        // stuck high -> timeout; following fall arrives in IDLE
        hold(1'b1, 6000);
        chk("high_tmo",    timeout,   1);
        chk("high_period", period,    1000);
        hold(1'b0, 20);
        pwm_cycles(7, 1, 4);
        chk("p7b_period", period,    7);
        chk("p7b_high",   high_time, 1);
        chk("p7b_tmo",    timeout,   0);

        // reset mid-HIGH
        pwm_cycles(1000, 100, 2);
        hold(1'b1, 50);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_period",  period,    0);
        chk("midrst_high",    high_time, 0);
        chk("midrst_valid",   valid,     0);
        chk("midrst_timeout", timeout,   0);
        hold(1'b0, 5);
        reset_n = 1'b1;
        pwm_cycles(1000, 300, 3);
        chk("post_period", period,    1000);
        chk("post_high",   high_time, 300);
        hold(1'b0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
